// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: default sizes and the one-hot address decode helper
package regfile_scoreboard_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int MAX_ADDR_WIDTH = 8;
  function automatic logic dec_hit(input logic [MAX_ADDR_WIDTH-1:0] addr, input int unsigned idx);
    return 32'(addr) == idx;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: write, issue and dual-read ports of the register file
interface regfile_scoreboard_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  logic                  ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic                  ctrl_issue;
  logic [ADDR_WIDTH-1:0] ctrl_issueReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  logic                  busyA;
  logic                  busyB;
  logic [NUM_REGS-1:0]   pending;
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_issue, ctrl_issueReg,
           ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB, busyA, busyB, pending
  );
  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_issue, ctrl_issueReg,
           ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB, busyA, busyB, pending
  );
endinterface

// File: rtl/regfile_cell.sv
// regfile_cell: one register with write enable and async active-low clear
module regfile_cell
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  ctrl_resetn,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge ctrl_resetn)
    if (!ctrl_resetn) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with r0 hardwired to zero, write bypass
// and a pending-producer scoreboard
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int BYPASS = 1
) (
  input logic clock,
  input logic ctrl_resetn,
  regfile_scoreboard_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] mux_a, mux_b;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [MAX_ADDR_WIDTH-1:0] wa, ia, ra, rb;
  logic wr_ok, iss_ok, fwd_a, fwd_b;
  assign wa = MAX_ADDR_WIDTH'(bus.ctrl_writeReg);
  assign ia = MAX_ADDR_WIDTH'(bus.ctrl_issueReg);
  assign ra = MAX_ADDR_WIDTH'(bus.ctrl_readRegA);
  assign rb = MAX_ADDR_WIDTH'(bus.ctrl_readRegB);
  // gating with reset keeps forwarded data off the read ports while in reset
  assign wr_ok = ctrl_resetn && bus.ctrl_writeEnable && bus.ctrl_writeReg != '0;
  assign iss_ok = bus.ctrl_issue && bus.ctrl_issueReg != '0;
  assign regs[0] = '0;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    regfile_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clock,
      .ctrl_resetn,
      .en(wr_ok && dec_hit(wa, g)),
      .d(bus.data_writeReg),
      .q(regs[g])
    );
  end
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mux_a = mux_a | ({DATA_WIDTH{dec_hit(ra, unsigned'(i))}} & regs[i]);
      mux_b = mux_b | ({DATA_WIDTH{dec_hit(rb, unsigned'(i))}} & regs[i]);
    end
  end
  // issue is OR'd after the clear term so a same-edge issue wins
  always_comb begin
    pend_d = '0;
    for (int i = 1; i < NUM_REGS; i++)
      pend_d[i] = (iss_ok && dec_hit(ia, unsigned'(i))) ||
                  (pend_q[i] && !(wr_ok && dec_hit(wa, unsigned'(i))));
  end
  always_ff @(posedge clock or negedge ctrl_resetn)
    if (!ctrl_resetn) pend_q <= '0;
    else pend_q <= pend_d;
  assign fwd_a = BYPASS != 0 && wr_ok && wa == ra;
  assign fwd_b = BYPASS != 0 && wr_ok && wa == rb;
  assign bus.data_readRegA = fwd_a ? bus.data_writeReg : mux_a;
  assign bus.data_readRegB = fwd_b ? bus.data_writeReg : mux_b;
  assign bus.busyA = pend_q[bus.ctrl_readRegA] && !fwd_a;
  assign bus.busyB = pend_q[bus.ctrl_readRegB] && !fwd_b;
  assign bus.pending = pend_q;
endmodule
